// File: rtl/mdu_pkg.sv
// +--------------------------------------------------------------------+
// | mdu_pkg : Op and FSM state encodings for the HI/LO multiply/divide |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package mdu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return op[0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/cneg.sv
// +--------------------------------------------------------------------+
// | cneg : conditional two's-complement negate, dout = neg ? -din : din |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module cneg #(
   parameter int W = 32
) (
   input  logic         neg,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   assign dout = neg ? (~din + W'(1)) : din;

endmodule

`default_nettype wire

// File: rtl/mdu_hilo.sv
// +--------------------------------------------------------------------+
// | mdu_hilo : iterative signed/unsigned MULT/DIV owning the HI/LO pair |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module mdu_hilo
   import mdu_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         Clk,
   input  logic         Clr,
   input  logic         Start,
   input  logic [1:0]   Op,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         Hi_Ld,
   input  logic         Lo_Ld,
   input  logic [W-1:0] Wr_Data,
   output logic         Busy,
   output logic         Done,
   output logic         Div_Zero,
   output logic [W-1:0] Hi,
   output logic [W-1:0] Lo
);

   localparam int CNT_W = $clog2(W) + 1;
   localparam logic [CNT_W-1:0] c_last = CNT_W'(W - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2*W-1:0]   r_acc;
   logic [W-1:0]     r_opnd;
   logic             r_is_div;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_dz_pend;
   logic             r_done;
   logic             r_dz;
   logic [W-1:0]     r_hi;
   logic [W-1:0]     r_lo;

   logic             w_a_neg;
   logic             w_b_neg;
   logic             w_div0;
   logic [W-1:0]     w_a_mag;
   logic [W-1:0]     w_b_mag;
   logic [W:0]       w_sum;
   logic [2*W-1:0]   w_mul_next;
   logic [W:0]       w_rem;
   logic [W:0]       w_diff;
   logic [2*W-1:0]   w_div_next;
   logic [2*W-1:0]   w_prod;
   logic [W-1:0]     w_quo_fix;
   logic [W-1:0]     w_rem_fix;

   assign w_a_neg = op_is_signed(Op) & A[W-1];
   assign w_b_neg = op_is_signed(Op) & B[W-1];
   assign w_div0  = op_is_div(Op) && (B == '0);

   cneg #(.W(W)) u_a_mag (.neg(w_a_neg), .din(A), .dout(w_a_mag));
   cneg #(.W(W)) u_b_mag (.neg(w_b_neg), .din(B), .dout(w_b_mag));

   // Shift-add: the W+1 bit sum keeps the carry out of the upper half.
   assign w_sum      = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_opnd};
   assign w_mul_next = r_acc[0] ? {w_sum, r_acc[W-1:1]} : {1'b0, r_acc[2*W-1:1]};

   // Restoring divide: bit W of the difference is the borrow.
   assign w_rem      = r_acc[2*W-1:W-1];
   assign w_diff     = w_rem - {1'b0, r_opnd};
   assign w_div_next = w_diff[W] ? {w_rem[W-1:0], r_acc[W-2:0], 1'b0}
                                 : {w_diff[W-1:0], r_acc[W-2:0], 1'b1};

   cneg #(.W(2*W)) u_prod_fix (.neg(r_neg_q), .din(r_acc),          .dout(w_prod));
   cneg #(.W(W))   u_quo_fix  (.neg(r_neg_q), .din(r_acc[W-1:0]),   .dout(w_quo_fix));
   cneg #(.W(W))   u_rem_fix  (.neg(r_neg_r), .din(r_acc[2*W-1:W]), .dout(w_rem_fix));

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_acc     <= '0;
         r_opnd    <= '0;
         r_is_div  <= 1'b0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_dz_pend <= 1'b0;
         r_done    <= 1'b0;
         r_dz      <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (Start) begin
                  r_dz      <= 1'b0;
                  r_cnt     <= '0;
                  r_is_div  <= op_is_div(Op);
                  r_dz_pend <= w_div0;
                  if (w_div0) begin
                     // Divide by zero skips RUN; FIN's divide path emits {A, all-ones}.
                     r_acc   <= {A, {W{1'b1}}};
                     r_neg_q <= 1'b0;
                     r_neg_r <= 1'b0;
                     r_state <= ST_FIN;
                  end else begin
                     r_neg_q <= w_a_neg ^ w_b_neg;
                     r_neg_r <= op_is_div(Op) & w_a_neg;
                     r_opnd  <= op_is_div(Op) ? w_b_mag : w_a_mag;
                     r_acc   <= {{W{1'b0}}, (op_is_div(Op) ? w_a_mag : w_b_mag)};
                     r_state <= ST_RUN;
                  end
               end else begin
                  if (Hi_Ld) r_hi <= Wr_Data;
                  if (Lo_Ld) r_lo <= Wr_Data;
               end
            end
            ST_RUN: begin
               r_acc <= r_is_div ? w_div_next : w_mul_next;
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == c_last) r_state <= ST_FIN;
            end
            ST_FIN: begin
               if (r_is_div) begin
                  r_hi <= w_rem_fix;
                  r_lo <= w_quo_fix;
               end else begin
                  r_hi <= w_prod[2*W-1:W];
                  r_lo <= w_prod[W-1:0];
               end
               r_dz    <= r_dz_pend;
               r_done  <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign Busy     = (r_state != ST_IDLE);
   assign Done     = r_done;
   assign Div_Zero = r_dz;
   assign Hi       = r_hi;
   assign Lo       = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_hilo.sv
// +--------------------------------------------------------------------+
// | tb_mdu_hilo : self-checking bench for mdu_hilo (W=32)              |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mdu_hilo;
   import mdu_pkg::*;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } vec_t;

   logic        Clk = 1'b0;
   logic        Clr = 1'b1;
   logic        Start = 1'b0;
   logic [1:0]  Op = 2'b00;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        Hi_Ld = 1'b0;
   logic        Lo_Ld = 1'b0;
   logic [31:0] Wr_Data = '0;
   logic        Busy;
   logic        Done;
   logic        Div_Zero;
   logic [31:0] Hi;
   logic [31:0] Lo;

   int n_checks = 0;
   int n_errors = 0;
   int cyc_now  = 0;
   int t0       = 0;
   logic r_prev_done = 1'b0;
   exp_t q[$];
   vec_t tbl[12];

   mdu_hilo #(.W(32)) dut (
      .Clk(Clk), .Clr(Clr), .Start(Start), .Op(Op), .A(A), .B(B),
      .Hi_Ld(Hi_Ld), .Lo_Ld(Lo_Ld), .Wr_Data(Wr_Data),
      .Busy(Busy), .Done(Done), .Div_Zero(Div_Zero), .Hi(Hi), .Lo(Lo)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc_now <= cyc_now + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      logic [63:0] p;
      longint sa, sb, qq, rr;
      e.dz = 1'b0;
      if (op == OP_MULTU) begin
         p = {32'b0, a} * {32'b0, b};
         e.hi = p[63:32]; e.lo = p[31:0];
      end else if (op == OP_MULT) begin
         sa = longint'($signed(a)); sb = longint'($signed(b));
         p = 64'(sa * sb);
         e.hi = p[63:32]; e.lo = p[31:0];
      end else if (b == 32'h0) begin
         e.hi = a; e.lo = 32'hFFFFFFFF; e.dz = 1'b1;
      end else begin
         if (op == OP_DIVU) begin
            sa = longint'({32'b0, a}); sb = longint'({32'b0, b});
         end else begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
         end
         qq = sa / sb; rr = sa % sb;
         e.hi = rr[31:0]; e.lo = qq[31:0];
      end
      return e;
   endfunction

   // Scoreboard: every Done pops the oldest expected result.
   always @(negedge Clk) begin
      exp_t e;
      if (Done) begin
         check("done_not_consecutive", {31'b0, r_prev_done}, 32'd0);
         if (q.size() == 0) begin
            check("done_unexpected", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            check("hi", Hi, e.hi);
            check("lo", Lo, e.lo);
            check("div_zero", {31'b0, Div_Zero}, {31'b0, e.dz});
            check("busy_in_done", {31'b0, Busy}, 32'd0);
         end
      end
      r_prev_done <= Done;
   end

   task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input exp_t e, input logic lo_ld);
      @(negedge Clk);
      Start = 1'b1; Op = op; A = a; B = b; Lo_Ld = lo_ld; Wr_Data = 32'h5555AAAA;
      q.push_back(e);
      @(posedge Clk); #1;
      t0 = cyc_now;
      Start = 1'b0; Lo_Ld = 1'b0;
      A = $urandom; B = $urandom; Op = 2'($urandom_range(0, 3));
      check("busy_after_start", {31'b0, Busy}, 32'd1);
      check("div_zero_cleared", {31'b0, Div_Zero}, 32'd0);
   endtask

   task automatic wait_done(input int lat);
      int n;
      n = 0;
      while (n < 100) begin
         @(posedge Clk); #1;
         n++;
         if (Done) break;
      end
      check("latency", 32'(cyc_now - t0), 32'(lat));
   endtask

   initial begin
      exp_t e;
      logic [1:0]  rop;
      logic [31:0] ra, rb;

      tbl[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0};
      tbl[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      tbl[2]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
      tbl[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      tbl[4]  = '{OP_DIV,   32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
      tbl[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      tbl[6]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
      tbl[7]  = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
      tbl[8]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};
      tbl[9]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
      tbl[10] = '{OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
      tbl[11] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};

      #1;
      check("rst_hi", Hi, 32'd0);
      check("rst_lo", Lo, 32'd0);
      check("rst_busy", {31'b0, Busy}, 32'd0);
      check("rst_done", {31'b0, Done}, 32'd0);
      check("rst_dz", {31'b0, Div_Zero}, 32'd0);
      repeat (2) @(negedge Clk);
      Clr = 1'b0;

      for (int i = 0; i < 12; i++) begin
         e.hi = tbl[i].hi; e.lo = tbl[i].lo; e.dz = tbl[i].dz;
         launch(tbl[i].op, tbl[i].a, tbl[i].b, e, 1'b0);
         wait_done(tbl[i].dz ? 1 : 33);
      end

      for (int i = 0; i < 6; i++) begin
         rop = 2'(i % 4); ra = $urandom; rb = (i == 5) ? 32'd0 : 32'($urandom);
         e = model(rop, ra, rb);
         launch(rop, ra, rb, e, 1'b0);
         wait_done(e.dz ? 1 : 33);
      end

      // Direct loads in IDLE, then Start with a same-edge Lo_Ld.
      @(negedge Clk);
      Hi_Ld = 1'b1; Lo_Ld = 1'b1; Wr_Data = 32'hCAFEF00D;
      @(posedge Clk); #1;
      Hi_Ld = 1'b0; Lo_Ld = 1'b0;
      check("ld_both_hi", Hi, 32'hCAFEF00D);
      check("ld_both_lo", Lo, 32'hCAFEF00D);
      e.hi = 32'd0; e.lo = 32'd15; e.dz = 1'b0;
      launch(OP_MULTU, 32'd3, 32'd5, e, 1'b1);
      check("start_beats_ld", Lo, 32'hCAFEF00D);
      repeat (4) @(negedge Clk);
      Start = 1'b1; Op = OP_DIVU; A = 32'd9; B = 32'd0; Hi_Ld = 1'b1; Lo_Ld = 1'b1; Wr_Data = 32'h12345678;
      @(posedge Clk); #1;
      Start = 1'b0; Hi_Ld = 1'b0; Lo_Ld = 1'b0;
      check("busy_ld_hi", Hi, 32'hCAFEF00D);
      check("busy_ld_lo", Lo, 32'hCAFEF00D);
      wait_done(33);

      // Asynchronous clear during iteration 10.
      e.hi = 32'h0; e.lo = 32'h0; e.dz = 1'b0;
      launch(OP_MULT, 32'h00012345, 32'h00000777, e, 1'b0);
      repeat (10) @(posedge Clk);
      #2 Clr = 1'b1;
      #1;
      check("clr_hi", Hi, 32'd0);
      check("clr_lo", Lo, 32'd0);
      check("clr_busy", {31'b0, Busy}, 32'd0);
      q.delete();
      @(negedge Clk);
      Clr = 1'b0;

      @(negedge Clk);
      Hi_Ld = 1'b1; Wr_Data = 32'hCAFEF00D;
      @(posedge Clk); #1;
      Hi_Ld = 1'b0;
      check("hi_ld", Hi, 32'hCAFEF00D);
      check("hi_ld_lo_untouched", Lo, 32'd0);
      repeat (5) @(posedge Clk);
      #1;
      check("hold_hi", Hi, 32'hCAFEF00D);
      check("hold_busy", {31'b0, Busy}, 32'd0);
      check("scoreboard_empty", 32'(q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
